ppu_line_writer: RTL and testbench
==================================

Name: ppu_line_writer

Overview:
- Writer end of the PPU-to-VGA scanline buffer; the VGA side reads the same buffer.
- Takes the PPU pixel stream (pal_index, xIdx, yIdx) and corrects the pipeline lag between the coordinate and its pixel.
- Discards pixels outside the 256x240 visible area and queues accepted pixels in a small FIFO.
- Drives the write port of the dual-port 32-line x 256-pixel buffer (13-bit address) under a ready/valid handshake. Also produces frame/line markers and an overflow flag.

Parameters:
- PIX_LAG, 1, cycles by which pal_index trails xIdx; effective column x_eff = xIdx - PIX_LAG.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- LVL_W, 3, width of fifo_level; must equal log2(DEPTH)+1.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pix_en  in  1  PPU pixel strobe; inputs sampled only when high.
- pal_index  in  5  palette index for the pixel at x_eff.
- xIdx  in  9  PPU dot counter.
- yIdx  in  9  PPU scanline counter.
- wr_ready  in  1  buffer RAM accepts a write this cycle.
- clr_overflow  in  1  clears the overflow flag.
- wr_en  out  1  write valid (FIFO not empty).
- wr_addr  out  13  {y[4:0], x_eff[7:0]} of the head entry.
- wr_data  out  5  pal_index of the head entry.
- frame_start  out  1  one-cycle pulse: pixel (0,0) accepted.
- line_done  out  1  one-cycle pulse: pixel x_eff=255 accepted.
- overflow  out  1  sticky: a valid pixel was dropped because the FIFO was full.
- fifo_level  out  LVL_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (synchronous):
  - Registered outputs, one cycle after reset is sampled: wr_en=0, wr_addr=0, wr_data=0, frame_start=0, line_done=0, overflow=0, fifo_level=0.
  - The FIFO is flushed. Reset mid-operation discards all queued entries; no write is issued in the cycle after reset.
- Capture, combinational:
  - x_eff is the 9-bit value of xIdx - PIX_LAG, taken as valid only when xIdx >= PIX_LAG.
  - valid_pix = pix_en && xIdx >= PIX_LAG && x_eff <= 255 && yIdx <= 239.
  - Everything else is silently dropped: xIdx < PIX_LAG, x_eff 256..340, yIdx 240..261 (including pre-render line 261 and 511). Silent drops do not set overflow.
- Push: entry {yIdx[4:0], x_eff[7:0], pal_index} is written when valid_pix && (not full || pop this cycle).
- Pop: when wr_en && wr_ready.
- Output register:
  - wr_addr/wr_data always present the head entry (show-ahead) and are held stable while wr_en=1 and wr_ready=0.
  - wr_en=1 exactly when fifo_level != 0.
- Latency: with the FIFO empty, a pixel pushed in cycle N appears on wr_en/wr_addr/wr_data in cycle N+1. Throughput is one pixel per cycle while wr_ready=1.
- Simultaneous events:
  - Push and pop in the same cycle leave the level unchanged.
  - At level=DEPTH with pop and valid_pix together, the push is accepted; level stays DEPTH and no overflow.
  - Push at full without pop: the pixel is dropped and overflow is set in cycle N+1.
  - FIFO pointers wrap modulo DEPTH.
- overflow: sticky, cleared by reset or clr_overflow. If clr_overflow and a new drop coincide, set wins.
- frame_start: pulses high in cycle N+1 when a pixel with x_eff=0, yIdx=0 is pushed.
- line_done: pulses in cycle N+1 when a pixel with x_eff=255 is pushed. A dropped pixel produces neither pulse.
- Line-buffer address wrap: yIdx[4:0] indexes the 32-line buffer, so line 32 reuses the rows of line 0. Overwriting is intentional.

Test Plan:
- Basic write, PIX_LAG=1:
  - Stimulus: pix_en=1, wr_ready=1, yIdx=3; xIdx sweeps 0..257 with pal_index=xIdx[4:0].
  - Response: exactly 256 writes; the first has wr_addr=0x0300, wr_data=0x01; the last has wr_addr=0x03FF.
  - line_done pulses once, one cycle after xIdx=256.
- Clipping:
  - Stimulus: yIdx=240, xIdx=10, pix_en=1.
  - Response: no write, overflow stays 0. Same for xIdx=0, yIdx=5.
- Backpressure, DEPTH=4:
  - Stimulus: wr_ready=0, six consecutive valid pixels.
  - Response: fifo_level reaches 4; overflow=1 after the 5th; wr_addr held stable.
  - Then wr_ready=1: exactly 4 writes, in order, of the first four pixels.
- Full with simultaneous push/pop:
  - Stimulus: level=4, wr_ready=1, valid_pix each cycle.
  - Response: level stays 4, no overflow, one write per cycle.
- Frame marker and wrap:
  - Stimulus: pixel at xIdx=1, yIdx=0.
  - Response: frame_start pulses one cycle later.
  - Stimulus: pixel at yIdx=33, x_eff=7.
  - Response: wr_addr=0x0107.
- Reset mid-stream:
  - Stimulus: level=3, then assert reset for one cycle.
  - Response: next cycle wr_en=0, fifo_level=0, overflow=0; the first pixel after reset is written normally.

Source files
------------

// File: rtl/ppu_line_writer.sv
// Scanline-buffer writer: clips the PPU pixel stream to 256x240, queues pixels, drives the RAM write port.
// Latency: a pixel accepted in cycle N is presented on wr_en/wr_addr/wr_data in cycle N+1.
// Backpressure: wr_ready low holds the head entry; a visible pixel arriving at full without a pop is dropped and sets overflow.
module ppu_line_writer #(
    parameter int PIX_LAG = 1,
    parameter int DEPTH   = 4,
    parameter int LVL_W   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pix_en,
    input  logic [4:0]       pal_index,
    input  logic [8:0]       xIdx,
    input  logic [8:0]       yIdx,
    input  logic             wr_ready,
    input  logic             clr_overflow,
    output logic             wr_en,
    output logic [12:0]      wr_addr,
    output logic [4:0]       wr_data,
    output logic             frame_start,
    output logic             line_done,
    output logic             overflow,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]       LAG      = 9'(PIX_LAG);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef struct packed {
        logic [12:0] addr;
        logic [4:0]  dat;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             frame_start_q, frame_start_d;
    logic             line_done_q, line_done_d;

    logic [8:0] x_eff;
    logic       valid_pix;
    logic       full;
    logic       pop;
    logic       push;
    entry_t     new_entry;
    entry_t     head;

    always_comb begin
        x_eff     = xIdx - LAG;
        // x_eff[8] set means the column is past 255 (or xIdx < LAG wrapped around)
        valid_pix = pix_en && (xIdx >= LAG) && !x_eff[8] && (yIdx <= 9'd239);
        full      = (level_q == FULL_LVL);
        pop       = (level_q != '0) && wr_ready;
        push      = valid_pix && (!full || pop);
        new_entry = '{addr: {yIdx[4:0], x_eff[7:0]}, dat: pal_index};

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

        // a fresh drop wins over a coincident clear
        if (valid_pix && !push) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        frame_start_d = push && (x_eff == 9'd0) && (yIdx == 9'd0);
        line_done_d   = push && (x_eff[7:0] == 8'hFF);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            frame_start_q <= 1'b0;
            line_done_q   <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            overflow_q    <= overflow_d;
            frame_start_q <= frame_start_d;
            line_done_q   <= line_done_d;
        end
    end

    always_comb begin
        head        = mem_q[rd_ptr_q];
        wr_en       = (level_q != '0);
        wr_addr     = wr_en ? head.addr : 13'd0;
        wr_data     = wr_en ? head.dat : 5'd0;
        frame_start = frame_start_q;
        line_done   = line_done_q;
        overflow    = overflow_q;
        fifo_level  = level_q;
    end

endmodule

// File: tb/tb_ppu_line_writer.sv
// Randomized and directed stimulus against a queue-based reference model; a negedge monitor scores every write.
module tb_ppu_line_writer;

    localparam int PIX_LAG = 1;
    localparam int DEPTH   = 4;
    localparam int LVL_W   = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             pix_en = 1'b0;
    logic [4:0]       pal_index = '0;
    logic [8:0]       xIdx = '0;
    logic [8:0]       yIdx = '0;
    logic             wr_ready = 1'b0;
    logic             clr_overflow = 1'b0;
    logic             wr_en;
    logic [12:0]      wr_addr;
    logic [4:0]       wr_data;
    logic             frame_start;
    logic             line_done;
    logic             overflow;
    logic [LVL_W-1:0] fifo_level;

    ppu_line_writer #(.PIX_LAG(PIX_LAG), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clock(clock), .reset(reset), .pix_en(pix_en), .pal_index(pal_index),
        .xIdx(xIdx), .yIdx(yIdx), .wr_ready(wr_ready), .clr_overflow(clr_overflow),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_start(frame_start),
        .line_done(line_done), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clock = ~clock;

    typedef struct {
        int addr;
        int dat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_cnt   = 0;
    bit   m_ovf   = 0;
    bit   m_fs    = 0;
    bit   m_ld    = 0;
    int   n_wr    = 0;
    int   n_fs    = 0;
    int   n_ld    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: spec rules on plain integers, occupancy as a count.
    int mx_eff;
    bit mv, mpop, mpush;
    always @(posedge clock) begin
        if (reset) begin
            sb.delete();
            m_cnt = 0;
            m_ovf = 0;
            m_fs  = 0;
            m_ld  = 0;
        end else begin
            mx_eff = int'(xIdx) - PIX_LAG;
            mv     = pix_en && (mx_eff >= 0) && (mx_eff < 256) && (int'(yIdx) < 240);
            mpop   = (m_cnt > 0) && wr_ready;
            mpush  = mv && ((m_cnt < DEPTH) || mpop);
            if (mpush) sb.push_back('{addr: (int'(yIdx) % 32) * 256 + mx_eff, dat: int'(pal_index)});
            m_cnt = m_cnt + int'(mpush) - int'(mpop);
            if (mv && !mpush) m_ovf = 1;
            else if (clr_overflow) m_ovf = 0;
            m_fs = mpush && (mx_eff == 0) && (yIdx == 0);
            m_ld = mpush && (mx_eff == 255);
        end
    end

    exp_t e;
    bit   prev_stall = 0;
    int   prev_addr  = 0;
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            check("wr_en", int'(wr_en), int'(m_cnt != 0));
            check("fifo_level", int'(fifo_level), m_cnt);
            check("overflow", int'(overflow), int'(m_ovf));
            check("frame_start", int'(frame_start), int'(m_fs));
            check("line_done", int'(line_done), int'(m_ld));
            if (prev_stall) check("hold_addr", int'(wr_addr), prev_addr);
            if (wr_en && wr_ready) begin
                n_wr++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", int'(wr_addr), e.addr);
                    check("wr_data", int'(wr_data), e.dat);
                end
            end
            n_fs += int'(frame_start);
            n_ld += int'(line_done);
            prev_stall = wr_en && !wr_ready;
            prev_addr  = int'(wr_addr);
        end
    end

    task automatic cyc(input bit en, input int x, input int y, input int pal,
                       input bit rdy, input bit clr = 0, input bit rst = 0);
        pix_en       = en;
        xIdx         = 9'(x);
        yIdx         = 9'(y);
        pal_index    = 5'(pal);
        wr_ready     = rdy;
        clr_overflow = clr;
        reset        = rst;
        @(posedge clock);
        #1;
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_overflow", int'(overflow), 0);

        // basic sweep of one visible line
        n_wr = 0; n_ld = 0;
        for (int x = 0; x <= 257; x++) cyc(1, x, 3, x % 32, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        check("basic_writes", n_wr, 256);
        check("basic_line_done", n_ld, 1);

        // clipping
        n_wr = 0;
        cyc(1, 10, 240, 3, 1);
        cyc(1, 0, 5, 4, 1);
        cyc(1, 300, 5, 4, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);
        check("clip_writes", n_wr, 0);
        check("clip_overflow", int'(overflow), 0);

        // backpressure and overflow
        n_wr = 0;
        for (int i = 0; i < 6; i++) cyc(1, 20 + i, 7, i + 1, 0);
        check("bp_level", int'(fifo_level), 4);
        check("bp_overflow", int'(overflow), 1);
        repeat (6) cyc(0, 0, 0, 0, 1);
        check("bp_writes", n_wr, 4);
        cyc(0, 0, 0, 0, 1, 1);
        check("clr_overflow", int'(overflow), 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 4; i++) cyc(1, 40 + i, 9, i, 0);
        for (int i = 0; i < 8; i++) cyc(1, 50 + i, 9, i + 8, 1);
        check("full_pp_level", int'(fifo_level), 4);
        check("full_pp_overflow", int'(overflow), 0);
        repeat (5) cyc(0, 0, 0, 0, 1);

        // frame marker and line wrap
        n_fs = 0;
        cyc(1, 1, 0, 9, 1);
        cyc(0, 0, 0, 0, 1);
        check("frame_start_cnt", n_fs, 1);
        cyc(1, 8, 33, 5, 0);
        check("wrap_addr", int'(wr_addr), 'h107);
        check("wrap_data", int'(wr_data), 5);
        repeat (2) cyc(0, 0, 0, 0, 1);

        // reset mid-stream
        for (int i = 0; i < 5; i++) cyc(1, 60 + i, 11, i, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("mid_rst_wr_en", int'(wr_en), 0);
        check("mid_rst_level", int'(fifo_level), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        n_wr = 0;
        cyc(1, 51, 2, 7, 1);
        check("post_rst_addr", int'(wr_addr), 'h232);
        cyc(0, 0, 0, 0, 1);
        check("post_rst_writes", n_wr, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 340),
                ($urandom_range(0, 4) != 0) ? $urandom_range(0, 250) : $urandom_range(0, 511),
                $urandom_range(0, 31), $urandom_range(0, 1) == 1,
                $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
        end

        // bounded drain
        for (int i = 0; i < 50 && (m_cnt != 0 || sb.size() != 0); i++) cyc(0, 0, 0, 0, 1);
        check("drain_model_empty", m_cnt, 0);
        check("drain_scoreboard", sb.size(), 0);
        check("drain_dut_level", int'(fifo_level), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
